// File: rtl/ctrl_seq_pkg.sv
// Shared state encoding for the ctrl_seq multi-cycle sequencer.
package ctrl_seq_pkg;

  localparam int CTRL_STATE_W = 3;

  typedef enum logic [CTRL_STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_LS   = 3'd4,
    ST_WB   = 3'd5,
    ST_HALT = 3'd6,
    ST_ERR  = 3'd7
  } ctrl_state_e;

  // True while an instruction is in flight (perf cycle counting).
  function automatic logic state_active(input ctrl_state_e st);
    return (st != ST_IDLE) && (st != ST_HALT) && (st != ST_ERR);
  endfunction

endpackage

// File: rtl/ctrl_seq_tmo.sv
// Memory-wait counter: saturating up-counter whose expired flag marks the
// cycle in which the count would reach 2^TMO_WIDTH-1.
module ctrl_seq_tmo #(
  parameter int TMO_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam logic [TMO_WIDTH-1:0] CNT_MAX  = {TMO_WIDTH{1'b1}};
  localparam logic [TMO_WIDTH-1:0] CNT_LAST = {{(TMO_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [TMO_WIDTH-1:0] CNT_ONE  = {{(TMO_WIDTH-1){1'b0}}, 1'b1};

  logic [TMO_WIDTH-1:0] r_cnt;

  // Clear has priority; the counter saturates at max instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {TMO_WIDTH{1'b0}};
    end else if (clear) begin
      r_cnt <= {TMO_WIDTH{1'b0}};
    end else if (count_en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // The caller only consults this while still waiting, so a same-cycle ack wins.
  assign expired = (r_cnt == CNT_LAST);

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle instruction sequencer IF->ID->EX->[LS]->WB with memory timeout.
// Optional performance counters are enabled by defining CTRL_SEQ_PERF_EN.
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int TMO_WIDTH = 8
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst_n,
  output logic       o_ifu_req,
  input  logic       i_ifu_ack,
  output logic       o_idu_en,
  output logic       o_exu_en,
  input  logic       i_idu_mem_en,
  input  logic       i_exu_halt,
  output logic       o_lsu_req,
  input  logic       i_lsu_ack,
  output logic       o_wbu_valid,
  input  logic       i_ifu_ready,
  output logic       o_halt,
  output logic       o_err,
  output logic [2:0] o_state
`ifdef CTRL_SEQ_PERF_EN
  ,
  output logic [31:0] o_perf_cycle,
  output logic [31:0] o_perf_instret
`endif
);

  ctrl_state_e r_state;
  ctrl_state_e w_state_nxt;
  logic        w_expired;
  logic        w_count_en;
  logic        w_clear;
  logic        r_ifu_req, r_idu_en, r_exu_en, r_lsu_req, r_wbu_valid, r_halt, r_err;

  // Next-state selection; HALT and ERR are absorbing.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_IF;
      ST_IF: begin
        if (i_ifu_ack)      w_state_nxt = ST_ID;
        else if (w_expired) w_state_nxt = ST_ERR;
        else                w_state_nxt = ST_IF;
      end
      ST_ID: w_state_nxt = ST_EX;
      ST_EX: begin
        if (i_exu_halt)        w_state_nxt = ST_HALT;
        else if (i_idu_mem_en) w_state_nxt = ST_LS;
        else                   w_state_nxt = ST_WB;
      end
      ST_LS: begin
        if (i_lsu_ack)      w_state_nxt = ST_WB;
        else if (w_expired) w_state_nxt = ST_ERR;
        else                w_state_nxt = ST_LS;
      end
      ST_WB: begin
        if (i_ifu_ready) w_state_nxt = ST_IF;
        else             w_state_nxt = ST_WB;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  assign w_count_en = ((r_state == ST_IF) && !i_ifu_ack) ||
                      ((r_state == ST_LS) && !i_lsu_ack);
  assign w_clear    = (w_state_nxt != r_state);

  ctrl_seq_tmo #(.TMO_WIDTH(TMO_WIDTH)) u_tmo (
    .clk      (i_sys_clk),
    .rst_n    (i_sys_rst_n),
    .count_en (w_count_en),
    .clear    (w_clear),
    .expired  (w_expired)
  );

  // State plus Moore outputs registered from the next state, so every output
  // is a pure function of the state register and drops with the async reset.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state     <= ST_IDLE;
      r_ifu_req   <= 1'b0;
      r_idu_en    <= 1'b0;
      r_exu_en    <= 1'b0;
      r_lsu_req   <= 1'b0;
      r_wbu_valid <= 1'b0;
      r_halt      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ifu_req   <= (w_state_nxt == ST_IF);
      r_idu_en    <= (w_state_nxt == ST_ID);
      r_exu_en    <= (w_state_nxt == ST_EX);
      r_lsu_req   <= (w_state_nxt == ST_LS);
      r_wbu_valid <= (w_state_nxt == ST_WB);
      r_halt      <= (w_state_nxt == ST_HALT);
      r_err       <= (w_state_nxt == ST_ERR);
    end
  end

  assign o_ifu_req   = r_ifu_req;
  assign o_idu_en    = r_idu_en;
  assign o_exu_en    = r_exu_en;
  assign o_lsu_req   = r_lsu_req;
  assign o_wbu_valid = r_wbu_valid;
  assign o_halt      = r_halt;
  assign o_err       = r_err;
  assign o_state     = r_state;

`ifdef CTRL_SEQ_PERF_EN
  logic [31:0] r_perf_cycle;
  logic [31:0] r_perf_instret;

  // Cycle and retired-instruction counters; both freeze once parked.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_perf_cycle   <= 32'd0;
      r_perf_instret <= 32'd0;
    end else begin
      r_perf_cycle   <= state_active(r_state) ? (r_perf_cycle + 32'd1) : r_perf_cycle;
      r_perf_instret <= ((r_state == ST_WB) && i_ifu_ready) ? (r_perf_instret + 32'd1)
                                                            : r_perf_instret;
    end
  end

  assign o_perf_cycle   = r_perf_cycle;
  assign o_perf_instret = r_perf_instret;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed, table-driven bench for ctrl_seq (built with TMO_WIDTH=4).
module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ifu_ack = 1'b0, mem_en = 1'b0, halt_in = 1'b0, lsu_ack = 1'b0, ifu_ready = 1'b0;
  logic       ifu_req, idu_en, exu_en, lsu_req, wbu_valid, halt_o, err_o;
  logic [2:0] state;
`ifdef CTRL_SEQ_PERF_EN
  logic [31:0] perf_cycle, perf_instret;
`endif

  int n_checks = 0;
  int n_errors = 0;

  ctrl_seq #(.TMO_WIDTH(4)) dut (
    .i_sys_clk    (clk),
    .i_sys_rst_n  (rst_n),
    .o_ifu_req    (ifu_req),
    .i_ifu_ack    (ifu_ack),
    .o_idu_en     (idu_en),
    .o_exu_en     (exu_en),
    .i_idu_mem_en (mem_en),
    .i_exu_halt   (halt_in),
    .o_lsu_req    (lsu_req),
    .i_lsu_ack    (lsu_ack),
    .o_wbu_valid  (wbu_valid),
    .i_ifu_ready  (ifu_ready),
    .o_halt       (halt_o),
    .o_err        (err_o),
    .o_state      (state)
`ifdef CTRL_SEQ_PERF_EN
    ,
    .o_perf_cycle   (perf_cycle),
    .o_perf_instret (perf_instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ifu_ack;
    logic       mem_en;
    logic       halt;
    logic       lsu_ack;
    logic       ifu_ready;
    logic [2:0] exp_state;
  } vec_t;

  vec_t vecs[22];

  // Expected output bundle {state, ifu_req, idu_en, exu_en, lsu_req, wbu_valid, halt, err}.
  function automatic logic [9:0] expect_outs(input logic [2:0] st);
    logic [6:0] oh;
    case (st)
      3'd1:    oh = 7'b1000000;
      3'd2:    oh = 7'b0100000;
      3'd3:    oh = 7'b0010000;
      3'd4:    oh = 7'b0001000;
      3'd5:    oh = 7'b0000100;
      3'd6:    oh = 7'b0000010;
      3'd7:    oh = 7'b0000001;
      default: oh = 7'b0000000;
    endcase
    return {st, oh};
  endfunction

  function automatic vec_t mk(input logic a, input logic m, input logic h,
                              input logic l, input logic r, input logic [2:0] s);
    vec_t v;
    v.ifu_ack = a; v.mem_en = m; v.halt = h; v.lsu_ack = l; v.ifu_ready = r; v.exp_state = s;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string name, input logic [2:0] st);
    chk(name, {22'd0, state, ifu_req, idu_en, exu_en, lsu_req, wbu_valid, halt_o, err_o},
        {22'd0, expect_outs(st)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic a, input logic m, input logic h, input logic l, input logic r);
    ifu_ack = a; mem_en = m; halt_in = h; lsu_ack = l; ifu_ready = r;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    chk_outs("reset_outs", 3'd0);
    step();
    rst_n = 1'b1;
    chk_outs("idle_after_release", 3'd0);
  endtask

  initial begin
    // Non-memory instr, load with 3 waits, WB backpressure, halt priority.
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    vecs[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4);
    vecs[8]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    vecs[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    vecs[14] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd3);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5);
    vecs[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5);
    vecs[18] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    vecs[19] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    vecs[20] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    vecs[21] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd6);

    do_reset();
    for (int i = 0; i < 22; i++) begin
      set_in(vecs[i].ifu_ack, vecs[i].mem_en, vecs[i].halt, vecs[i].lsu_ack, vecs[i].ifu_ready);
      step();
      chk_outs($sformatf("vec%0d", i), vecs[i].exp_state);
    end

    // HALT is absorbing whatever the inputs do.
    for (int i = 0; i < 20; i++) begin
      set_in(i[0], i[1], i[2], ~i[0], 1'b1);
      step();
      chk_outs($sformatf("halt_hold%0d", i), 3'd6);
    end
`ifdef CTRL_SEQ_PERF_EN
    chk("perf_cycle_frozen", perf_cycle, 32'd21);
    chk("perf_instret", perf_instret, 32'd3);
`endif

    // Fetch timeout: 15 unacknowledged IF cycles lead to ERR.
    do_reset();
    step();
    chk_outs("tmo_if_entry", 3'd1);
    for (int i = 0; i < 14; i++) step();
    chk_outs("tmo_still_if", 3'd1);
    step();
    chk_outs("tmo_err", 3'd7);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      step();
      chk_outs($sformatf("err_hold%0d", i), 3'd7);
    end

    // Ack on the 15th wait cycle wins over the timeout.
    do_reset();
    step();
    for (int i = 0; i < 14; i++) step();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_outs("tmo_ack_wins", 3'd2);

    // Load/store timeout follows the same rule.
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk_outs("ls_entry", 3'd4);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step();
    chk_outs("ls_still_waiting", 3'd4);
    step();
    chk_outs("ls_tmo_err", 3'd7);

    // Asynchronous reset in the middle of LS.
    do_reset();
    step();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_outs("pre_async_ls", 3'd4);
    #3;
    rst_n = 1'b0;
    #1;
    chk_outs("async_reset_ls", 3'd0);
`ifdef CTRL_SEQ_PERF_EN
    chk("async_perf_cycle", perf_cycle, 32'd0);
    chk("async_perf_instret", perf_instret, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
